// File: rtl/dispatch_issue_queue.sv
// In-order dispatch FIFO: buffers decoded instructions and issues the head to its
// one-hot selected execution unit, serializing privileged ops against in-flight work.
package cvw_pkg;
  typedef struct packed {
    int unsigned XLEN;
  } cvw_t;
endpackage

module dispatch_issue_queue
  import cvw_pkg::*;
#(
  parameter cvw_t        P           = '{XLEN: 32'd64},
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MAXINFLIGHT = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             FlushD,
  input  logic                             InstrValidD,
  output logic                             InstrReadyD,
  input  logic [31:0]                      InstrD,
  input  logic [P.XLEN-1:0]                PCD,
  input  logic [5:0]                       UnitSelD,
  output logic [5:0]                       IssueValid,
  input  logic [5:0]                       IssueReady,
  output logic [31:0]                      IssueInstr,
  output logic [P.XLEN-1:0]                IssuePC,
  output logic                             IssueIllegal,
  input  logic [5:0]                       UnitDone,
  output logic [$clog2(DEPTH+1)-1:0]       QueueCount,
  output logic [$clog2(MAXINFLIGHT+1)-1:0] InFlight
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned FW = $clog2(MAXINFLIGHT + 1);
  localparam int unsigned SW = FW + 3;
  localparam logic [5:0]  SEL_PRIV = 6'b000001;

  typedef struct packed {
    logic [31:0]       instr;
    logic [P.XLEN-1:0] pc;
    logic [5:0]        sel;
    logic              illegal;
  } entry_t;

  entry_t         mem_q [DEPTH];
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic [FW-1:0]  inflight_q, inflight_d;
  logic           priv_q, priv_d;
  logic           nonempty, eligible, enq, fire, underflow, sel_onehot;
  logic [SW-1:0]  done_cnt, infl_sum;
  entry_t         head, new_entry;

  always_comb begin
    head       = mem_q[head_q];
    nonempty   = (count_q != '0);
    sel_onehot = (UnitSelD != '0) && ((UnitSelD & (UnitSelD - 6'd1)) == '0);

    new_entry.instr   = InstrD;
    new_entry.pc      = PCD;
    new_entry.sel     = sel_onehot ? UnitSelD : SEL_PRIV;
    new_entry.illegal = ~sel_onehot;

    InstrReadyD = ~reset && (count_q < CW'(DEPTH));
    enq         = InstrValidD && InstrReadyD && ~FlushD;

    // Priv heads wait for an empty pipeline; anything after a Priv waits for it to retire.
    eligible = nonempty && ~FlushD && ~priv_q && (inflight_q < FW'(MAXINFLIGHT))
               && (~head.sel[0] || (inflight_q == '0));
    IssueValid   = eligible ? head.sel : '0;
    fire         = |(IssueValid & IssueReady);
    IssueInstr   = nonempty ? head.instr : '0;
    IssuePC      = nonempty ? head.pc : '0;
    IssueIllegal = nonempty && head.illegal;
    QueueCount   = count_q;
    InFlight     = inflight_q;

    done_cnt = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      done_cnt = done_cnt + SW'(UnitDone[i]);
    end
    infl_sum   = SW'(inflight_q) + SW'(fire);
    underflow  = (infl_sum < done_cnt);
    inflight_d = underflow ? '0 : FW'(infl_sum - done_cnt);

    if (fire && head.sel[0]) begin
      priv_d = 1'b1;
    end else if (inflight_q == '0) begin
      priv_d = 1'b0;
    end else begin
      priv_d = priv_q;
    end

    if (FlushD) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = fire ? head_q + PW'(1) : head_q;
      tail_d  = enq ? tail_q + PW'(1) : tail_q;
      count_d = count_q + CW'(enq) - CW'(fire);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      priv_q     <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      priv_q     <= priv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[tail_q] <= new_entry;
    end
  end

  assert property (@(posedge clk) disable iff (reset) !underflow);
endmodule
